// File: rtl/mmm_pkg.sv
// Shared types and timing constants for the MMM unit's MAC feeder.
package mmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        HOLD
    } feeder_state_t;

    localparam int unsigned MAC_LAT   = 2;
    localparam int unsigned SRAM_LAT  = 1;
    localparam int unsigned DRAIN_LEN = MAC_LAT + SRAM_LAT;

endpackage

// File: rtl/mac_addr_gen.sv
// Running base+stride address counter; wraps modulo 2^AW by natural overflow.
module mac_addr_gen #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] stride_q, stride_d;

    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
        end else if (step) begin
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/mac_feeder.sv
// Sequences SRAM operand fetches into one pipelined MAC lane and returns the
// accumulated dot product on a valid/ready result port.
module mac_feeder
    import mmm_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 32,
    parameter int unsigned AW   = 8,
    parameter int unsigned LENW = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LENW-1:0] len,
    input  logic [AW-1:0]   a_base,
    input  logic [AW-1:0]   b_base,
    input  logic [AW-1:0]   b_stride,
    output logic            busy,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_rdata,
    output logic            b_rd_en,
    output logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_rdata,
    output logic            mac_clear,
    output logic            mac_valid,
    output logic [DW-1:0]   mac_in0,
    output logic [DW-1:0]   mac_in1,
    input  logic [ACCW-1:0] mac_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ACCW-1:0] res_data
);

    localparam int unsigned DCW = $clog2(DRAIN_LEN);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_LEN - 1);

    feeder_state_t   state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] idx_q, idx_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [ACCW-1:0] res_data_q, res_data_d;
    logic            mac_valid_q, mac_valid_d;
    logic            load;
    logic            issue;
    logic [AW-1:0]   a_gen_addr;
    logic [AW-1:0]   b_gen_addr;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        res_data_d = res_data_q;
        load       = 1'b0;
        issue      = 1'b0;
        mac_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    len_d   = len;
                    idx_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clear = 1'b1;
                drain_d   = '0;
                state_d   = (len_q != '0) ? ISSUE : DRAIN;
            end
            ISSUE: begin
                issue = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == len_q - 1'b1) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last drain cycle: final pair has just landed in mac_out.
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    res_data_d = mac_out;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mac_valid_d = issue;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            res_data_q  <= '0;
            mac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            res_data_q  <= res_data_d;
            mac_valid_q <= mac_valid_d;
        end
    end

    mac_addr_gen #(.AW(AW)) u_a_addr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (issue),
        .base  (a_base),
        .stride(AW'(1)),
        .addr  (a_gen_addr)
    );

    mac_addr_gen #(.AW(AW)) u_b_addr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (issue),
        .base  (b_base),
        .stride(b_stride),
        .addr  (b_gen_addr)
    );

    assign busy      = (state_q != IDLE);
    assign a_rd_en   = issue;
    assign b_rd_en   = issue;
    assign a_addr    = issue ? a_gen_addr : '0;
    assign b_addr    = issue ? b_gen_addr : '0;
    assign mac_valid = mac_valid_q;
    assign mac_in0   = mac_valid_q ? a_rdata : '0;
    assign mac_in1   = mac_valid_q ? b_rdata : '0;
    assign res_valid = (state_q == HOLD);
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: SRAM and saturating MAC environment, a timeline model
// checked every cycle, and directed jobs with literal expectations.
module tb_mac_feeder;

    localparam int DW   = 8;
    localparam int ACCW = 16;
    localparam int AW   = 8;
    localparam int LENW = 7;
    localparam longint SMAX = (64'sd1 <<< (ACCW - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (ACCW - 1));

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [LENW-1:0] len = '0;
    logic [AW-1:0]   a_base = '0, b_base = '0, b_stride = '0;
    logic            busy, a_rd_en, b_rd_en, mac_clear, mac_valid, res_valid;
    logic [AW-1:0]   a_addr, b_addr;
    logic [DW-1:0]   a_rdata, b_rdata, mac_in0, mac_in1;
    logic [ACCW-1:0] mac_out, res_data;
    logic            res_ready = 1'b1;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [7:0] a_mem [256];
    logic [7:0] b_mem [256];
    logic [7:0] baddr_q [$];
    int         mv_q [$];

    mac_feeder #(.DW(DW), .ACCW(ACCW), .AW(AW), .LENW(LENW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .a_base(a_base), .b_base(b_base), .b_stride(b_stride), .busy(busy),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .mac_clear(mac_clear), .mac_valid(mac_valid),
        .mac_in0(mac_in0), .mac_in1(mac_in1), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic longint dot(input int n, input logic [7:0] ab, input logic [7:0] bb,
                                   input logic [7:0] st);
        longint acc = 0;
        logic signed [7:0] x, y;
        for (int i = 0; i < n; i++) begin
            x = a_mem[8'(int'(ab) + i)];
            y = b_mem[8'(int'(bb) + i * int'(st))];
            acc = sat(acc + longint'(x) * longint'(y));
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Synchronous-read SRAMs
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= a_mem[a_addr];
        if (b_rd_en) b_rdata <= b_mem[b_addr];
    end

    // Saturating MAC: pair valid in cycle k visible in mac_out from k+2
    logic signed [ACCW-1:0] acc_q;
    logic signed [2*DW-1:0] prod_q;
    logic                   pv_q;
    always @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            prod_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            pv_q   <= mac_valid;
            prod_q <= $signed(mac_in0) * $signed(mac_in1);
            if (mac_clear) acc_q <= '0;
            else if (pv_q) acc_q <= ACCW'(sat(longint'(acc_q) + longint'(prod_q)));
        end
    end
    assign mac_out = acc_q;

    // Timeline model: t = cycles since the accepted start
    bit         m_active = 1'b0;
    int         m_t0 = 0, m_len = 0;
    logic [7:0] m_ab, m_bb, m_st;
    longint     m_res = 0;

    always @(negedge clk) begin
        int t, k;
        bit e_busy, e_clr, e_iss, e_mv, e_rv;
        logic [7:0] e_aa, e_ba, e_i0, e_i1;
        if (chk_en) begin
            t      = cyc - m_t0;
            k      = t - 3;
            e_busy = m_active && t >= 1;
            e_clr  = m_active && t == 1;
            e_iss  = m_active && t >= 2 && t <= m_len + 1;
            e_mv   = m_active && t >= 3 && t <= m_len + 2;
            e_rv   = m_active && t >= m_len + 5;
            e_aa   = e_iss ? 8'(int'(m_ab) + t - 2) : 8'h00;
            e_ba   = e_iss ? 8'(int'(m_bb) + (t - 2) * int'(m_st)) : 8'h00;
            e_i0   = e_mv ? a_mem[8'(int'(m_ab) + k)] : 8'h00;
            e_i1   = e_mv ? b_mem[8'(int'(m_bb) + k * int'(m_st))] : 8'h00;
            check("busy", 64'(busy), 64'(e_busy));
            check("mac_clear", 64'(mac_clear), 64'(e_clr));
            check("a_rd_en", 64'(a_rd_en), 64'(e_iss));
            check("b_rd_en", 64'(b_rd_en), 64'(e_iss));
            check("a_addr", 64'(a_addr), 64'(e_aa));
            check("b_addr", 64'(b_addr), 64'(e_ba));
            check("mac_valid", 64'(mac_valid), 64'(e_mv));
            check("mac_in0", 64'(mac_in0), 64'(e_i0));
            check("mac_in1", 64'(mac_in1), 64'(e_i1));
            check("res_valid", 64'(res_valid), 64'(e_rv));
            if (e_rv) check("res_data", 64'($signed(res_data)), m_res);
            if (b_rd_en) baddr_q.push_back(b_addr);
            if (mac_valid) mv_q.push_back(cyc);
            if (reset) begin
                m_active = 1'b0;
            end else if (!m_active && start) begin
                m_active = 1'b1;
                m_t0  = cyc;
                m_len = int'(len);
                m_ab  = a_base;
                m_bb  = b_base;
                m_st  = b_stride;
                m_res = dot(m_len, m_ab, m_bb, m_st);
            end else if (e_rv && res_ready) begin
                m_active = 1'b0;
            end
        end
    end

    int last_t0 = 0;

    // Starts a job next cycle, returns at the negedge of the first res_valid cycle
    task automatic run_job(input int n, input logic [7:0] ab, input logic [7:0] bb,
                           input logic [7:0] st, output int rel, output logic signed [63:0] data);
        bit found = 1'b0;
        rel  = -1;
        data = '0;
        @(posedge clk); #1;
        len = LENW'(n); a_base = ab; b_base = bb; b_stride = st; start = 1'b1;
        last_t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("res_valid_timeout", 0, 1);
        else begin
            rel  = cyc - last_t0;
            data = 64'($signed(res_data));
        end
    endtask

    int rel;
    logic signed [63:0] d;

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 8'h00;
            b_mem[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            a_mem[i]        = 8'(i + 1);
            b_mem[8'h10 + i] = 8'(i + 5);
        end
        b_mem[8'hF8] = 8'h01; b_mem[8'hFC] = 8'hFF; b_mem[8'h00] = 8'h02; b_mem[8'h04] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            a_mem[8'h40 + i] = 8'd127; b_mem[8'h40 + i] = 8'd127;
            a_mem[8'h50 + i] = 8'h80;  b_mem[8'h50 + i] = 8'd127;
        end
        for (int i = 0; i < 2; i++) begin
            a_mem[8'h60 + i] = 8'd3; b_mem[8'h60 + i] = 8'd2;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_a_rd_en", 64'(a_rd_en), 0);
        check("rst_mac_clear", 64'(mac_clear), 0);
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_res_data", 64'(res_data), 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        baddr_q.delete(); mv_q.delete();
        run_job(4, 8'h00, 8'h10, 8'h01, rel, d);
        check("t1_data", d, 70);
        check("t1_latency", rel, 9);
        check("t1_baddr_n", baddr_q.size(), 4);
        if (baddr_q.size() == 4) begin
            check("t1_baddr0", baddr_q[0], 8'h10);
            check("t1_baddr3", baddr_q[3], 8'h13);
        end
        check("t1_mv_n", mv_q.size(), 4);
        if (mv_q.size() == 4) begin
            check("t1_mv_first", mv_q[0] - last_t0, 3);
            check("t1_mv_last", mv_q[3] - last_t0, 6);
        end

        baddr_q.delete();
        run_job(4, 8'h00, 8'hF8, 8'h04, rel, d);
        check("t2_data", d, 17);
        check("t2_baddr_n", baddr_q.size(), 4);
        if (baddr_q.size() == 4) begin
            check("t2_baddr0", baddr_q[0], 8'hF8);
            check("t2_baddr1", baddr_q[1], 8'hFC);
            check("t2_baddr2", baddr_q[2], 8'h00);
            check("t2_baddr3", baddr_q[3], 8'h04);
        end

        run_job(3, 8'h40, 8'h40, 8'h01, rel, d);
        check("sat_pos", d, 32767);
        run_job(3, 8'h50, 8'h50, 8'h01, rel, d);
        check("sat_neg", d, -32768);

        baddr_q.delete();
        run_job(0, 8'h40, 8'h40, 8'h01, rel, d);
        check("len0_data", d, 0);
        check("len0_latency", rel, 5);
        check("len0_no_rd", baddr_q.size(), 0);

        // Backpressure: hold result while a stray start arrives
        @(posedge clk); #1;
        res_ready = 1'b0;
        run_job(2, 8'h00, 8'h10, 8'h01, rel, d);
        check("hold_data", d, 17);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            len   = 7'd5;
            start = (i == 3);
        end
        start = 1'b0;
        @(negedge clk);
        check("hold_valid", 64'(res_valid), 1);
        check("hold_busy", 64'(busy), 1);
        check("hold_stable", 64'($signed(res_data)), 17);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("release_busy", 64'(busy), 0);
        run_job(4, 8'h00, 8'h10, 8'h01, rel, d);
        check("after_hold_data", d, 70);

        // Reset in the second ISSUE cycle
        @(posedge clk); #1;
        len = 7'd4; a_base = 8'h00; b_base = 8'h10; b_stride = 8'h01; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 0);
        check("abort_rd_en", 64'({a_rd_en, b_rd_en}), 0);
        check("abort_addr", 64'({a_addr, b_addr}), 0);
        check("abort_mac", 64'({mac_clear, mac_valid, mac_in0, mac_in1}), 0);
        check("abort_res_valid", 64'(res_valid), 0);
        check("abort_res_data", 64'(res_data), 0);
        run_job(2, 8'h60, 8'h60, 8'h01, rel, d);
        check("post_reset_data", d, 12);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Sequencing initiator for one saturating pipelined MAC lane.
- On start, it fetches operand vectors from two synchronous-read SRAMs and clears the MAC accumulator.
- It streams one operand pair per cycle with a valid strobe, waits out the MAC pipeline, then captures the accumulated dot product.
- The result is presented on a valid/ready output port to the MMM unit's result collector.

Parameters:
- DW, 8: operand width; matches MAC input width.
- ACCW, 32: accumulator/result width; matches MAC output width.
- AW, 8: SRAM address width.
- LENW, 7: width of vector-length field; max len = 2^LENW-1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  LENW  vector length, latched on accepted start
- a_base  in  AW  A-vector base address, latched on start
- b_base  in  AW  B-vector base address, latched on start
- b_stride  in  AW  B address increment per element, latched on start
- busy  out  1  high in every state except IDLE
- a_rd_en  out  1  A SRAM read enable
- a_addr  out  AW  A SRAM address
- a_rdata  in  DW  signed A data, valid the cycle after a_rd_en
- b_rd_en  out  1  B SRAM read enable
- b_addr  out  AW  B SRAM address
- b_rdata  in  DW  signed B data, valid the cycle after b_rd_en
- mac_clear  out  1  accumulator clear to MAC
- mac_valid  out  1  operand-pair valid to MAC
- mac_in0  out  DW  operand A to MAC
- mac_in1  out  DW  operand B to MAC
- mac_out  in  ACCW  signed saturated accumulator from MAC
- res_valid  out  1  result available
- res_ready  in  1  collector accepts result
- res_data  out  ACCW  captured signed result

Behaviour:
- Reset values: busy=0, all rd_en=0, addresses=0, mac_clear=0, mac_valid=0, mac_in0/1=0, res_valid=0, res_data=0. FSM goes to IDLE, counters go to 0. The MAC shares reset.
- Reset mid-operation aborts immediately. Any pending result is discarded. No partial result is ever emitted.
- MAC contract (fixed): a pair with mac_valid high in cycle k is reflected in mac_out from cycle k+2. mac_clear zeroes the accumulator at the next edge and has priority over accumulation.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, HOLD.
  - IDLE: on start=1, latch len, a_base, b_base and b_stride, set idx=0, go to CLEAR.
  - CLEAR: mac_clear=1 for exactly this cycle. Next state is ISSUE if len!=0, else DRAIN.
  - ISSUE: a_rd_en=b_rd_en=1, a_addr=a_base+idx, b_addr=b_base+idx*b_stride. Addresses wrap modulo 2^AW and are kept as a running sum, not a multiplier. idx increments each cycle; after idx==len-1, go to DRAIN.
  - DRAIN: fixed 3 cycles (1 SRAM + 2 MAC). At the end of the third cycle, register mac_out into res_data, go to HOLD.
  - HOLD: res_valid=1 and res_data stable. When res_ready=1, go to IDLE at the next edge with res_valid=0.
- Data path: mac_valid is a_rd_en delayed one cycle. mac_in0=a_rdata and mac_in1=b_rdata, combinational pass-through in the data-return cycle. mac_valid=0 forces no accumulation; operand values are don't-care then.
- Latency: start in cycle 0 gives CLEAR in cycle 1, ISSUE in cycles 2..len+1, and res_valid first high in cycle len+5. For len=0, res_valid is high in cycle 5 with res_data=0.
- Throughput: one element per cycle; no bubbles inside ISSUE.
- start while busy is ignored, not queued.
- res_ready while not res_valid has no effect. res_valid does not depend combinationally on res_ready.
- Next job: start may be accepted in the IDLE cycle immediately after the HOLD handshake.
- Saturation is owned by the MAC. The feeder never modifies mac_out.

Decomposition:
- Shared package mmm_pkg holds:
  - state enum feeder_state_t {IDLE, CLEAR, ISSUE, DRAIN, HOLD};
  - localparam MAC_LAT=2 and SRAM_LAT=1, with DRAIN length = MAC_LAT+SRAM_LAT.
- One natural sub-module: mac_addr_gen, the base+stride running-address counter with wrap, instantiated twice (A with stride 1, B with b_stride).

Test Plan:
- len=4, A=[1,2,3,4] at 0x00, B=[5,6,7,8] at 0x10, stride 1 -> res_data=70, res_valid in cycle 9, b_addr 0x10..0x13, mac_valid high in cycles 3..6.
- len=4, b_base=0xF8, b_stride=4 -> b_addr sequence 0xF8, 0xFC, 0x00, 0x04 (wrap); result matches a software model.
- ACCW=16, len=3, all A=B=127 -> 16129, 32258, then saturates: res_data=32767. Also A=-128, B=127 x3 -> res_data=-32768.
- len=0 -> mac_clear pulse, no rd_en, res_valid in cycle 5, res_data=0.
- res_ready held low 10 cycles -> res_valid and res_data stable, busy=1, extra start ignored. Release -> IDLE, next start yields a correct, independently cleared result.
- reset asserted in the 2nd ISSUE cycle -> next cycle all outputs at reset values, no res_valid. A following start with len=2, A=[3,3], B=[2,2] -> res_data=12.
